// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Shared definitions for the memory port arbiter and its lane-alignment
// helper: RISC-V load/store funct3 encodings, the arbiter FSM state encoding,
// the access-size decode and the default starvation limit.
//
// No ports (package).
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Load funct3 encodings.
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store funct3 encodings.
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    // Consecutive LS grants tolerated while IF waits (starvation build only).
    localparam int DEFAULT_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_LS_BUSY = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Access width of a load or store; any encoding that is not a legal
    // byte/halfword operation is treated as a word access.
    function automatic size_t access_size(input logic we, input logic [2:0] funct3);
        size_t sz;
        sz = SZ_WORD;
        if (we) begin
            case (funct3)
                SB:      sz = SZ_BYTE;
                SH:      sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end else begin
            case (funct3)
                LB, LBU: sz = SZ_BYTE;
                LH, LHU: sz = SZ_HALF;
                default: sz = SZ_WORD;
            endcase
        end
        return sz;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
//
// Purely combinational byte-lane steering for the shared memory port.
// From the access type and the low address bits it produces the byte enables,
// the lane-replicated store data, the right-aligned load data and the
// misalignment flag.
//
// Ports:
//   we          in   1   1 = store, 0 = load
//   funct3      in   3   load/store width encoding
//   addr_lo     in   2   byte offset within the word
//   wdata       in  32   store data, value in the low bits
//   rdata       in  32   raw word read from memory
//   be          out  4   byte enables (all ones for loads)
//   wdata_rep   out 32   store data replicated across all lanes
//   rdata_shift out 32   load data shifted down to bit 0, upper bits zero
//   misalign    out  1   halfword on odd address / word on non-zero offset
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_shift,
    output logic        misalign
);

    size_t size;

    // NOTE: every output gets a default at the top of the block so that no
    // path through the case statements leaves it unassigned (no latches).
    always_comb begin
        size        = access_size(we, funct3);
        be          = 4'b1111;
        wdata_rep   = wdata;
        misalign    = 1'b0;

        if (we) begin
            case (size)
                SZ_BYTE: begin
                    be        = 4'b0001 << addr_lo;
                    wdata_rep = {4{wdata[7:0]}};
                end
                SZ_HALF: begin
                    be        = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_rep = {2{wdata[15:0]}};
                end
                default: begin
                    be        = 4'b1111;
                    wdata_rep = wdata;
                end
            endcase
        end

        case (size)
            SZ_HALF: misalign = addr_lo[0];
            SZ_WORD: misalign = |addr_lo;
            default: misalign = 1'b0;
        endcase

        // Shift amount is 8 * byte offset.
        rdata_shift = rdata >> {addr_lo, 3'b000};
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares a single memory port between instruction fetch (IF) and the
// load/store unit (LS). Grants are combinational in IDLE, one transaction is
// held in flight until mem_ready, and responses are registered one-cycle
// pulses. Misaligned LS accesses are acknowledged with ls_misalign and never
// reach memory.
//
// Optional feature: define MEM_ARB_STARVE_EN to add a starvation counter that
// lets IF win a simultaneous request after STARVE_LIMIT consecutive LS grants.
// Without it LS always has priority.
//
// Parameters:
//   STARVE_LIMIT  1..15  LS grants allowed while IF waits (starvation build)
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr -> if_gnt      fetch request / accept
//   if_valid/if_rdata             fetch response pulse
//   ls_req/ls_we/ls_addr/ls_wdata/ls_funct3 -> ls_gnt   LS request / accept
//   ls_valid/ls_rdata/ls_misalign LS response pulse (rdata right-aligned)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be            memory request
//   mem_ready/mem_rdata           memory completion and read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,

    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_funct3,
    output logic        ls_gnt,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        ls_misalign,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
            $error("mem_port_arbiter: STARVE_LIMIT must be in 1..15");
        end
    endgenerate

    state_t      state;
    state_t      next_state;

    // Transaction captured at grant and replayed on the port while busy.
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_we;
    logic [2:0]  lat_funct3;

    // Lane aligner operates on the live LS request in IDLE (for byte enables
    // and misalignment) and on the latched request while busy (for the load
    // shift at completion).
    logic        lane_we;
    logic [2:0]  lane_funct3;
    logic [1:0]  lane_addr_lo;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;
    logic        lane_misalign;

    logic        if_override;

    always_comb begin
        if (state == ST_IDLE) begin
            lane_we      = ls_we;
            lane_funct3  = ls_funct3;
            lane_addr_lo = ls_addr[1:0];
        end else begin
            lane_we      = lat_we;
            lane_funct3  = lat_funct3;
            lane_addr_lo = lat_addr[1:0];
        end
    end

    mem_lane_align u_lane_align (
        .we          (lane_we),
        .funct3      (lane_funct3),
        .addr_lo     (lane_addr_lo),
        .wdata       (ls_wdata),
        .rdata       (mem_rdata),
        .be          (lane_be),
        .wdata_rep   (lane_wdata),
        .rdata_shift (lane_rdata),
        .misalign    (lane_misalign)
    );

`ifdef MEM_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    // Counter can never pass the limit: at the limit a waiting IF wins, and an
    // LS grant without a waiting IF clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= 4'd0;
        end else if (if_gnt) begin
            starve_cnt <= 4'd0;
        end else if (ls_gnt) begin
            starve_cnt <= if_req ? starve_cnt + 4'd1 : 4'd0;
        end
    end

    assign if_override = (starve_cnt == 4'(STARVE_LIMIT));
`else
    assign if_override = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (ls_gnt && !lane_misalign) begin
                    next_state = ST_LS_BUSY;
                end else if (if_gnt) begin
                    next_state = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY, ST_LS_BUSY: begin
                if (mem_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (grants and memory port)
    // -------------------------------------------------------------------------
    // mem_req decodes straight from the state register, so an asynchronous
    // reset drops it immediately.
    always_comb begin
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        case (state)
            ST_IDLE: begin
                if (if_req && (!ls_req || if_override)) begin
                    if_gnt = 1'b1;
                end else if (ls_req) begin
                    ls_gnt = 1'b1;
                end
            end
            ST_IF_BUSY, ST_LS_BUSY: begin
                mem_req   = 1'b1;
                mem_we    = lat_we;
                mem_addr  = {lat_addr[31:2], 2'b00};
                mem_wdata = lat_wdata;
                mem_be    = lat_be;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr    <= 32'd0;
            lat_wdata   <= 32'd0;
            lat_be      <= 4'd0;
            lat_we      <= 1'b0;
            lat_funct3  <= 3'd0;
            if_valid    <= 1'b0;
            if_rdata    <= 32'd0;
            ls_valid    <= 1'b0;
            ls_rdata    <= 32'd0;
            ls_misalign <= 1'b0;
        end else begin
            if_valid    <= 1'b0;
            ls_valid    <= 1'b0;
            ls_misalign <= 1'b0;

            if (ls_gnt) begin
                lat_addr   <= ls_addr;
                lat_we     <= ls_we;
                lat_funct3 <= ls_funct3;
                lat_be     <= lane_be;
                lat_wdata  <= lane_wdata;
                // Misaligned: answer next cycle without touching memory.
                if (lane_misalign) begin
                    ls_valid    <= 1'b1;
                    ls_misalign <= 1'b1;
                    ls_rdata    <= 32'd0;
                end
            end else if (if_gnt) begin
                lat_addr   <= if_addr;
                lat_we     <= 1'b0;
                lat_funct3 <= LW;
                lat_be     <= 4'b1111;
                lat_wdata  <= 32'd0;
            end

            if (mem_ready) begin
                case (state)
                    ST_IF_BUSY: begin
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                    ST_LS_BUSY: begin
                        ls_valid <= 1'b1;
                        ls_rdata <= lat_we ? 32'd0 : lane_rdata;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single memory port between instruction fetch (IF) and the load/store unit (LS). Arbitrates requests, holds one transaction in flight with wait-state support, and generates byte enables and replicated write data from funct3 and address. Right-aligns load data so the downstream writeback stage applies sign/zero extension directly. Flags misaligned load/store accesses without touching memory.

## Interface
- STARVE_LIMIT, 4: consecutive LS grants allowed while IF waits (used only with MEM_ARB_STARVE_EN); range 1–15.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req / if_addr  in  1 / 32  fetch request; address is word-aligned.
- if_gnt  out  1  fetch request accepted this cycle.
- if_valid / if_rdata  out  1 / 32  one-cycle fetch response.
- ls_req / ls_we / ls_addr / ls_wdata / ls_funct3  in  1/1/32/32/3  load/store request.
- ls_gnt  out  1  LS request accepted this cycle.
- ls_valid / ls_rdata / ls_misalign  out  1/32/1  one-cycle LS response; rdata right-aligned; misalign qualifies valid.
- mem_req / mem_we / mem_addr / mem_wdata / mem_be  out  1/1/32/32/4  memory port; addr is {addr[31:2],2'b00}.
- mem_ready / mem_rdata  in  1 / 32  memory completion and read data, sampled in the same cycle.

## Operation
- FSM states: IDLE, IF_BUSY, LS_BUSY.
- In IDLE, grants are combinational: if ls_req, then ls_gnt; else if if_req, then if_gnt. On grant, latch the request and enter the matching BUSY state.
- Misaligned LS request: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]≠0. The request is granted and the FSM stays IDLE. Next cycle: ls_valid=1, ls_misalign=1, ls_rdata=0. No mem_req is issued.
- In BUSY, mem_req=1 and all mem_* outputs are held stable until mem_ready=1. On that cycle, return to IDLE. Next cycle, the matching *_valid pulses with registered data.
- Byte enables and write data:
  - SB: be=4'b0001<<addr[1:0]; wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<{addr[1],1'b0}; wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111.
  - Loads: be=4'b1111, we=0.
- Load data: ls_rdata = mem_rdata >> (8*addr[1:0]), upper bits zero. Extension is done downstream.
- Invalid funct3 is treated as word access.
- Requesters must hold req and fields until granted. Dropping req before grant is allowed; nothing is issued.

## Timing
- Reset values: all outputs 0, state IDLE, starvation counter 0.
- Reset mid-transaction abandons it. mem_req deasserts asynchronously and no valid is produced.
- Minimum latency: grant at cycle N; mem_req at N+1; mem_ready at N+1 gives valid at N+2.
- Response-to-next-grant: one IDLE cycle minimum, giving at most one transaction per 2 cycles.
- Simultaneous if_req and ls_req in IDLE: LS wins, unless the starvation override applies.
- ls_valid and if_valid are never high in the same cycle.

## Configuration
- MEM_ARB_STARVE_EN defined: a 4-bit counter increments on each LS grant while if_req=1. It clears on any IF grant and when if_req=0 at an LS grant. When the counter equals STARVE_LIMIT, IF wins the next simultaneous request.
- MEM_ARB_STARVE_EN undefined: fixed LS priority. The counter and the STARVE_LIMIT logic are absent.

## Structure
- Shared package holds:
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW;
  - FSM state encoding;
  - the default STARVE_LIMIT.
- One sub-module, mem_lane_align, is fully combinational. From funct3, addr[1:0] and data it produces:
  - mem_be;
  - the replicated write data;
  - the load right-shift;
  - the misalign flag.

## Test plan
- IF-only read of 0x100, mem_ready 2 cycles after mem_req, rdata 0xDEADBEEF → if_gnt at N, mem_req held 3 cycles with addr 0x100, if_valid at N+4 with 0xDEADBEEF.
- SB at 0x203 with wdata 0x000000A5 → mem_addr 0x200, be 4'b1000, mem_wdata 0xA5A5A5A5, mem_we=1.
- LH at 0x402 with mem_rdata 0x8001_7FFF → ls_rdata 0x0000_8001.
- SW at 0x101 → ls_gnt, ls_valid with ls_misalign=1 next cycle, mem_req never asserted.
- if_req and ls_req held continuously, STARVE_LIMIT=4:
  - with the macro: 4 LS grants, then 1 IF grant, repeating;
  - without the macro: LS grants only.
- rst asserted while in LS_BUSY → mem_req low immediately, no ls_valid, next request is served normally from IDLE.
